// File: rtl/bus_rx_fifo.sv
// Receive-side FWFT FIFO terminal for one bus port: captures push/D_push, serves pndng/pop/D_pop.
// Optional destination filtering is enabled by defining BUS_RX_ID_CHECK_EN.
module bus_rx_fifo #(
  parameter int         width = 16,
  parameter int         depth = 8,
  parameter logic [7:0] id    = 8'h00,
  parameter logic [7:0] bcast = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [width-1:0]             D_push,
  input  logic                         pop,
  output logic [width-1:0]             D_pop,
  output logic                         pndng,
  output logic                         full,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow,
  output logic [15:0]                  rx_cnt,
  output logic                         misroute
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             dest_ok;
  logic             accept;
  logic             do_pop;

`ifdef BUS_RX_ID_CHECK_EN
  assign dest_ok = (D_push[width-1 -: 8] == id) || (D_push[width-1 -: 8] == bcast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misroute <= 1'b0;
    end else if (push && !dest_ok) begin
      misroute <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign dest_ok    = 1'b1;
  assign misroute   = 1'b0;
  assign unused_cfg = ^{id, bcast};
`endif

  assign pndng  = (count != '0);
  assign full   = (count == CW'(depth));
  // A pop frees the head slot at the same edge, so a full FIFO may still accept.
  assign accept = push && dest_ok && (!full || pop);
  assign do_pop = pop && pndng;
  assign D_pop  = pndng ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= D_push;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rx_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        rx_cnt <= rx_cnt + 16'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (accept && !do_pop) begin
        count <= count + CW'(1);
      end else if (!accept && do_pop) begin
        count <= count - CW'(1);
      end
      if (push && dest_ok && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_rx_fifo.sv
// Randomized and directed bench for bus_rx_fifo against a queue-based reference model.
// Build with or without BUS_RX_ID_CHECK_EN; the model follows the same macro.
module tb_bus_rx_fifo;

  localparam int         WIDTH = 16;
  localparam int         DEPTH = 8;
  localparam logic [7:0] ID    = 8'h03;
  localparam logic [7:0] BCAST = 8'hFF;

  logic              clk;
  logic              reset;
  logic              push;
  logic [WIDTH-1:0]  D_push;
  logic              pop;
  logic [WIDTH-1:0]  D_pop;
  logic              pndng;
  logic              full;
  logic [3:0]        count;
  logic              overflow;
  logic [15:0]       rx_cnt;
  logic              misroute;

  int checks;
  int errors;

  logic [WIDTH-1:0] q[$];
  int               m_rx;
  bit               m_ovf;
  bit               m_mis;

  bus_rx_fifo #(.width(WIDTH), .depth(DEPTH), .id(ID), .bcast(BCAST)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .count(count),
    .overflow(overflow), .rx_cnt(rx_cnt), .misroute(misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit dest_match(input logic [WIDTH-1:0] d);
`ifdef BUS_RX_ID_CHECK_EN
    return (d[WIDTH-1:WIDTH-8] == ID) || (d[WIDTH-1:WIDTH-8] == BCAST);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_rx  = 0;
    m_ovf = 1'b0;
    m_mis = 1'b0;
  endtask

  task automatic model_step(input bit p, input logic [WIDTH-1:0] d, input bit pp);
    bit was_full;
    bit was_pend;
    bit ok;
    was_full = (q.size() == DEPTH);
    was_pend = (q.size() != 0);
    ok = dest_match(d);
    if (p && !ok) m_mis = 1'b1;
    if (p && ok && was_full && !pp) m_ovf = 1'b1;
    if (pp && was_pend) void'(q.pop_front());
    if (p && ok && (!was_full || pp)) begin
      q.push_back(d);
      m_rx = (m_rx + 1) % 65536;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [WIDTH-1:0] head;
    head = (q.size() != 0) ? q[0] : '0;
    check({tag, ".pndng"},    32'(pndng),    32'(q.size() != 0));
    check({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
    check({tag, ".count"},    32'(count),    32'(q.size()));
    check({tag, ".D_pop"},    32'(D_pop),    32'(head));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".misroute"}, 32'(misroute), 32'(m_mis));
    check({tag, ".rx_cnt"},   32'(rx_cnt),   32'(m_rx));
  endtask

  // Inputs are applied between edges, the model advances on the edge, outputs are sampled 1ns later.
  task automatic cycle(input string tag, input bit p, input logic [WIDTH-1:0] d, input bit pp);
    push   = p;
    D_push = d;
    pop    = pp;
    @(posedge clk);
    model_step(p, d, pp);
    #1;
    compare_all(tag);
    push   = 1'b0;
    pop    = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #1;
    reset = 1'b0;
    #1;
    check({tag, ".count"},    32'(count),    32'd0);
    check({tag, ".pndng"},    32'(pndng),    32'd0);
    check({tag, ".full"},     32'(full),     32'd0);
    check({tag, ".D_pop"},    32'(D_pop),    32'd0);
    check({tag, ".overflow"}, 32'(overflow), 32'd0);
    check({tag, ".misroute"}, 32'(misroute), 32'd0);
    check({tag, ".rx_cnt"},   32'(rx_cnt),   32'd0);
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    D_push = '0;
    model_reset();
    #12;
    check("rst.count",    32'(count),    32'd0);
    check("rst.pndng",    32'(pndng),    32'd0);
    check("rst.full",     32'(full),     32'd0);
    check("rst.D_pop",    32'(D_pop),    32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    check("rst.misroute", 32'(misroute), 32'd0);
    check("rst.rx_cnt",   32'(rx_cnt),   32'd0);
    @(negedge clk);
    reset = 1'b1;

    cycle("single_push", 1'b1, 16'h0012, 1'b0);
    cycle("single_pop",  1'b0, 16'h0000, 1'b1);

    do_reset("rst2");
    for (int i = 1; i <= 9; i++) cycle("fill9", 1'b1, WIDTH'(i), 1'b0);
    for (int i = 0; i < 8; i++)  cycle("drain9", 1'b0, 16'h0000, 1'b1);

    do_reset("rst3");
    for (int i = 1; i <= 8; i++) cycle("fill8", 1'b1, WIDTH'(i), 1'b0);
    cycle("full_push_pop", 1'b1, 16'h00AA, 1'b1);
    for (int i = 0; i < 8; i++)  cycle("drain8", 1'b0, 16'h0000, 1'b1);

    for (int i = 0; i < 3; i++)  cycle("empty_pop", 1'b0, 16'h0000, 1'b1);
    cycle("empty_push_pop", 1'b1, 16'h0055, 1'b1);
    cycle("empty_push_pop_drain", 1'b0, 16'h0000, 1'b1);

    cycle("id_mis",   1'b1, 16'h0501, 1'b0);
    cycle("id_bcast", 1'b1, 16'hFF02, 1'b0);
    cycle("id_own",   1'b1, 16'h0303, 1'b0);

    for (int i = 0; i < 2; i++) cycle("load4", 1'b1, 16'h0340 + WIDTH'(i), 1'b0);
    do_reset("rst_mid");

    for (int i = 0; i < 20; i++) begin
      cycle("wrap_push", 1'b1, 16'h0300 + WIDTH'(i), 1'b0);
      cycle("wrap_pop",  1'b0, 16'h0000, 1'b1);
    end

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 2))
        0:       d[15:8] = ID;
        1:       d[15:8] = BCAST;
        default: d[15:8] = 8'($urandom);
      endcase
      d[7:0] = 8'($urandom);
      cycle("rand", ($urandom_range(0, 99) < 55), d, ($urandom_range(0, 99) < 45));
      if (i == 300) do_reset("rst_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_rx_fifo.md
# bus_rx_fifo

Receive-side FIFO terminal for one port of the `bs_gnrtr_n_rbtr` bus generator/arbiter. It sits at the far end of the bus from the transmit FIFOs that feed the arbiter through `pndng`/`pop`/`D_pop`. It captures packets the bus delivers on `push`/`D_push`, buffers them in a first-word-fall-through FIFO, and presents them to the consumer (monitor or downstream logic) through a `pndng`/`pop`/`D_pop` handshake. One instance per bus driver port.

## Interface
- `width`, 16: packet width in bits; `width >= 9`. The top 8 bits are the destination ID.
- `depth`, 8: FIFO depth in entries; power of two, `>= 2`.
- `id`, 0: 8-bit ID of this port.
- `bcast`, 8'hFF: broadcast destination ID.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  1  bus delivers a packet this cycle.
- `D_push`  in  width  delivered packet; valid when `push`=1.
- `pop`  in  1  consumer takes the head entry.
- `D_pop`  out  width  head entry; all zeros when `pndng`=0.
- `pndng`  out  1  FIFO non-empty.
- `full`  out  1  count == depth.
- `count`  out  $clog2(depth+1)  entries held.
- `overflow`  out  1  sticky: a push was dropped because the FIFO was full.
- `rx_cnt`  out  16  accepted-packet counter; wraps 16'hFFFF -> 0.
- `misroute`  out  1  sticky: a packet was dropped for wrong destination.

## Operation
- Storage is a `depth`-entry array with `wr_ptr` and `rd_ptr` (log2(depth) bits each, natural wrap) and a `count` register.
- Accept condition: `push`=1, the packet passes the destination check (see Configuration), and either `full`=0 or `pop`=1 in the same cycle.
- On accept: write `D_push` at `wr_ptr`, increment `wr_ptr`, increment `rx_cnt`.
- Pop condition: `pop`=1 and `pndng`=1. On pop: increment `rd_ptr`.
- `pop` with `pndng`=0 is ignored. There is no underflow state change.
- `count` update per edge: +1 on accept without pop, -1 on pop without accept, unchanged when both or neither occur.
- Push while full with no pop: the packet is dropped, `overflow` is set, and `rx_cnt` is unchanged.
- Push and pop together while empty: the packet is written and no pop occurs, because `pndng` was 0. Resulting `count`=1.
- Sticky flags clear only on reset.
- `D_pop` is combinational from `mem[rd_ptr]`, gated to zero when empty.

## Timing
- Reset (`reset`=0, asynchronous): `wr_ptr`=`rd_ptr`=0, `count`=0, `rx_cnt`=0. Outputs: `pndng`=0, `full`=0, `overflow`=0, `misroute`=0, `D_pop`=0. Memory contents are not reset.
- Reset asserted mid-operation discards all buffered data immediately. Reset deassertion is taken synchronously at the next `clk` edge.
- Write-to-read latency is 1 cycle. A packet pushed at edge N appears on `D_pop` with `pndng`=1 after edge N.
- Pop takes effect at the edge. The next entry (or zeros) appears after that edge.
- `full`, `pndng`, `count`, `overflow`, `misroute`, and `rx_cnt` all update at the same edge as the event that causes them.
- Full and pushing with pop in the same cycle: both occur, `count` stays at `depth`, and no overflow is flagged.

## Configuration
- Macro `BUS_RX_ID_CHECK_EN`.
- Defined: a packet is accepted only if `D_push[width-1:width-8]` equals `id` or `bcast`. A non-matching push is dropped, `misroute` is set, and FIFO and `rx_cnt` are unchanged. The ID check applies before the full check, so a misrouted push while full sets only `misroute`.
- Undefined: no destination check is made, every push is subject only to the full rule, and `misroute` is tied to 0.

## Test plan
- Reset, then push 16'h0012 with `id`=0. Required: `pndng`=1, `D_pop`=16'h0012, `count`=1, and `rx_cnt`=1 one edge later. Then pop, and `pndng`=0 and `D_pop`=0.
- Push 9 packets 16'h0001..16'h0009 with `depth`=8 and no pop. Required: `full`=1 after the 8th, the 9th is dropped, `overflow`=1, and `rx_cnt`=8. Draining must yield 1..8 in order.
- FIFO full, with `push`=1 (16'h00AA) and `pop`=1 in the same cycle. Required: `count` stays 8, `overflow`=0, and 16'h00AA is the last entry read.
- Empty FIFO with `pop`=1 for 3 cycles. Required: no change, `count`=0, `pndng`=0.
- With `BUS_RX_ID_CHECK_EN` and `id`=3: push 16'h0501 -> dropped with `misroute`=1. Push 16'hFF02 -> accepted. Push 16'h0303 -> accepted. Required: `count`=2. Without the macro, all 3 are accepted and `misroute`=0.
- Load 4 entries, assert `reset`=0 between edges. Required: `count`=0, `pndng`=0, and `D_pop`=0 immediately. Wrap test: 20 push/pop pairs return data in order across pointer wrap.
